// File: rtl/sample_run_ctrl.sv
// sample_run_ctrl: sequences one sampling run (clear, arm, run, drain)
// and owns the bus-mapped run control, counters and sticky status.
//
// Ports:
//   clk, rst_n           clock, async active-low reset
//   avalid/awe/aaddr/adata  bus request (write takes effect at its edge)
//   bvalid/bdata         registered response, one cycle after avalid
//   s                    synchronized inputs for trigger match
//   in_strobe            raw sample strobe from the strober
//   out_strobe           gated strobe to the compressor (combinational)
//   comp_clear           compressor clear pulse (CLEAR state)
//   comp_out_strobe      compressor word strobe, counted outside IDLE
//   comp_overflow        compressor overflow, sticky outside IDLE
//   strober_enable       strober timer enable (RUN state)
//   strober_clear_timer  strober timer clear pulse (CLEAR state)
//   run_active           high in ARMED, RUN or DRAIN
//   done                 one-cycle pulse after a normal drain

module sample_run_ctrl #(
  parameter int TRIG_W = 16,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              avalid,
  input  logic              awe,
  input  logic [4:0]        aaddr,
  input  logic [31:0]       adata,
  output logic              bvalid,
  output logic [31:0]       bdata,
  input  logic [TRIG_W-1:0] s,
  input  logic              in_strobe,
  output logic              out_strobe,
  output logic              comp_clear,
  input  logic              comp_out_strobe,
  input  logic              comp_overflow,
  output logic              strober_enable,
  output logic              strober_clear_timer,
  output logic              run_active,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CLEAR = 3'd1,
    S_ARMED = 3'd2,
    S_RUN   = 3'd3,
    S_DRAIN = 3'd4
  } state_e;

  localparam logic [4:0] A_CTRL  = 5'd0;
  localparam logic [4:0] A_MASK  = 5'd1;
  localparam logic [4:0] A_VALUE = 5'd2;
  localparam logic [4:0] A_LIMIT = 5'd3;
  localparam logic [4:0] A_SCNT  = 5'd4;
  localparam logic [4:0] A_WCNT  = 5'd5;

  state_e            state_q, state_d;
  logic              drain_q, drain_d;
  logic              done_q, done_d;
  logic [TRIG_W-1:0] mask_q, mask_d;
  logic [TRIG_W-1:0] value_q, value_d;
  logic [CNT_W-1:0]  limit_q, limit_d;
  logic [CNT_W-1:0]  scnt_q, scnt_d;
  logic [CNT_W-1:0]  wcnt_q, wcnt_d;
  logic              ovf_q, ovf_d;
  logic              lhit_q, lhit_d;
  logic              bvalid_q;
  logic [31:0]       bdata_q, bdata_d;
  logic [31:0]       rdata;

  logic             wr;
  logic             ctrl_wr;
  logic             cmd_abort;
  logic             cmd_stop;
  logic             cmd_start;
  logic             trig_hit;
  logic             in_run;
  logic             not_idle;
  logic             limit_reach;
  logic [CNT_W-1:0] scnt_inc;
  logic [CNT_W-1:0] wcnt_inc;

  // Command priority: abort > stop > start.
  assign wr        = avalid & awe;
  assign ctrl_wr   = wr & (aaddr == A_CTRL);
  assign cmd_abort = ctrl_wr & adata[2];
  assign cmd_stop  = ctrl_wr & adata[1] & ~adata[2];
  assign cmd_start = ctrl_wr & adata[0]
                   & ~adata[1] & ~adata[2];

  assign trig_hit = ((s ^ value_q) & mask_q) == '0;
  assign in_run   = (state_q == S_RUN);
  assign not_idle = (state_q != S_IDLE);

  assign out_strobe = in_strobe & in_run;

  // Saturating increments.
  assign scnt_inc = (&scnt_q) ? scnt_q
                              : scnt_q + CNT_W'(1);
  assign wcnt_inc = (&wcnt_q) ? wcnt_q
                              : wcnt_q + CNT_W'(1);

  assign limit_reach = out_strobe
                     & (limit_q != '0)
                     & (scnt_inc == limit_q);

  always_comb begin
    state_d = state_q;
    drain_d = drain_q;
    done_d  = 1'b0;
    mask_d  = mask_q;
    value_d = value_q;
    limit_d = limit_q;
    scnt_d  = scnt_q;
    wcnt_d  = wcnt_q;
    ovf_d   = ovf_q;
    lhit_d  = lhit_q;

    unique case (state_q)
      S_IDLE: ;
      S_CLEAR: state_d = S_ARMED;
      S_ARMED: begin
        if (trig_hit) state_d = S_RUN;
      end
      S_RUN: begin
        if (limit_reach) begin
          state_d = S_DRAIN;
          drain_d = 1'b0;
        end
      end
      S_DRAIN: begin
        // drain_q marks the second drain cycle.
        if (drain_q) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end else begin
          drain_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (out_strobe) scnt_d = scnt_inc;
    if (limit_reach) lhit_d = 1'b1;
    if (not_idle && comp_out_strobe)
      wcnt_d = wcnt_inc;
    if (not_idle && comp_overflow)
      ovf_d = 1'b1;

    if (cmd_abort && not_idle) begin
      state_d = S_IDLE;
      done_d  = 1'b0;
    end else if (cmd_stop &&
                 (state_q == S_ARMED ||
                  state_q == S_RUN)) begin
      state_d = S_DRAIN;
      drain_d = 1'b0;
    end else if (cmd_start && !not_idle) begin
      state_d = S_CLEAR;
      scnt_d  = '0;
      wcnt_d  = '0;
      ovf_d   = 1'b0;
      lhit_d  = 1'b0;
    end

    if (wr) begin
      unique case (1'b1)
        (aaddr == A_MASK):
          mask_d = adata[TRIG_W-1:0];
        (aaddr == A_VALUE):
          value_d = adata[TRIG_W-1:0];
        (aaddr == A_LIMIT):
          limit_d = adata[CNT_W-1:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    rdata = '0;
    case (aaddr)
      A_CTRL: begin
        rdata[2:0] = state_q;
        rdata[8]   = ovf_q;
        rdata[9]   = lhit_q;
      end
      A_MASK:  rdata[TRIG_W-1:0] = mask_q;
      A_VALUE: rdata[TRIG_W-1:0] = value_q;
      A_LIMIT: rdata[CNT_W-1:0]  = limit_q;
      A_SCNT:  rdata[CNT_W-1:0]  = scnt_q;
      A_WCNT:  rdata[CNT_W-1:0]  = wcnt_q;
      default: rdata = '0;
    endcase
  end

  // Reads return pre-edge register values;
  // write responses carry zero.
  assign bdata_d = (avalid && !awe) ? rdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      drain_q  <= 1'b0;
      done_q   <= 1'b0;
      mask_q   <= '0;
      value_q  <= '0;
      limit_q  <= '0;
      scnt_q   <= '0;
      wcnt_q   <= '0;
      ovf_q    <= 1'b0;
      lhit_q   <= 1'b0;
      bvalid_q <= 1'b0;
      bdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      drain_q  <= drain_d;
      done_q   <= done_d;
      mask_q   <= mask_d;
      value_q  <= value_d;
      limit_q  <= limit_d;
      scnt_q   <= scnt_d;
      wcnt_q   <= wcnt_d;
      ovf_q    <= ovf_d;
      lhit_q   <= lhit_d;
      bvalid_q <= avalid;
      bdata_q  <= bdata_d;
    end
  end

  assign bvalid              = bvalid_q;
  assign bdata               = bdata_q;
  assign comp_clear          = (state_q == S_CLEAR);
  assign strober_clear_timer = (state_q == S_CLEAR);
  assign strober_enable      = in_run;
  assign run_active          = (state_q == S_ARMED)
                             | (state_q == S_RUN)
                             | (state_q == S_DRAIN);
  assign done                = done_q;

endmodule

// File: doc/sample_run_ctrl.md
Name: sample_run_ctrl

Overview:
- Sequences one sampling run on the sampler datapath.
- Owns the register-mapped run control: start, stop, abort, trigger pattern and sample limit.
- Drives the compressor clear and the strober enable/timer-clear. Gates the raw sample strobe into the compressor.
- Sits between the bus register port and the strober/compressor pair. Reports run status, counters and overflow back over the bus.

Parameters:
- TRIG_W, 16, width of the sampled input and the trigger mask/value.
- CNT_W, 32, width of the sample limit, sample counter and word counter.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset: asynchronous, active-low
- avalid  in  1  bus request valid
- awe  in  1  bus write enable
- aaddr  in  5  register address
- adata  in  32  write data
- bvalid  out  1  read/write response valid
- bdata  out  32  read data
- s  in  TRIG_W  synchronized sample inputs, used for trigger match
- in_strobe  in  1  raw sample strobe from the strober
- out_strobe  out  1  gated sample strobe to the compressor
- comp_clear  out  1  compressor clear pulse
- comp_out_strobe  in  1  compressor output word strobe
- comp_overflow  in  1  compressor overflow_error
- strober_enable  out  1  strober period-timer enable
- strober_clear_timer  out  1  strober timer clear pulse
- run_active  out  1  high in ARMED, RUN or DRAIN
- done  out  1  one-cycle pulse when a run completes normally

Behaviour:
- Registers; unlisted reads return 0.
  - 0 CTRL. Write: bit0 start, bit1 stop, bit2 abort. Read: [2:0] state, bit8 overflow (sticky), bit9 limit_hit.
  - 1 TRIG_MASK, low TRIG_W bits.
  - 2 TRIG_VALUE, low TRIG_W bits.
  - 3 SAMPLE_LIMIT; 0 means unlimited.
  - 4 SAMPLE_COUNT, read-only.
  - 5 WORD_COUNT, read-only.
- Bus timing:
  - bvalid equals avalid delayed one cycle, for reads and writes.
  - bdata is registered and valid with bvalid.
  - A write takes effect on the clock edge that samples it.
- Reset values:
  - state IDLE; all registers and counters 0; overflow and limit_hit 0.
  - bvalid, bdata, out_strobe, comp_clear, strober_enable, strober_clear_timer, run_active, done all 0.
- State encoding: IDLE=0, CLEAR=1, ARMED=2, RUN=3, DRAIN=4.
- IDLE:
  - start -> CLEAR. Start is ignored in every other state.
  - A start edge also zeroes SAMPLE_COUNT and WORD_COUNT and clears overflow and limit_hit.
- CLEAR:
  - Lasts exactly 1 cycle, with comp_clear=1 and strober_clear_timer=1.
  - Then -> ARMED.
- ARMED:
  - Leave when (s & TRIG_MASK) == (TRIG_VALUE & TRIG_MASK), evaluated every cycle -> RUN.
  - MASK=0 matches immediately, so ARMED lasts 1 cycle.
- RUN:
  - strober_enable=1 (registered: high in the cycles the state is RUN).
  - out_strobe = in_strobe AND state==RUN. This path is combinational, zero latency.
  - Each out_strobe increments SAMPLE_COUNT.
  - If LIMIT≠0 and a strobe brings SAMPLE_COUNT to LIMIT: set limit_hit, -> DRAIN next cycle.
  - No further out_strobe after the limit; exactly LIMIT strobes are passed.
- DRAIN:
  - strober_enable=0 and out_strobe=0; any in_strobe is dropped and not counted.
  - Stays 2 cycles to let compressor output settle.
  - Then -> IDLE with done=1 for one cycle.
- stop:
  - In ARMED or RUN -> DRAIN.
  - In IDLE, CLEAR or DRAIN it is ignored.
- abort:
  - In any non-IDLE state -> IDLE next cycle. No done pulse; counters are kept.
- Priority within one write: abort > stop > start.
  - A start together with stop or abort in IDLE is ignored.
- WORD_COUNT:
  - Increments on comp_out_strobe in any state except IDLE.
  - In IDLE it holds its value.
- overflow:
  - Sets on comp_overflow in any non-IDLE state.
  - Cleared only by reset or a start.
- Counters saturate at all-ones and do not wrap.
- in_strobe and the limit hit in the same RUN cycle: the strobe passes and is counted, then DRAIN.
- rst_n asserted mid-run: all state returns to reset values immediately (async). No done pulse.

Test Plan:
- Reset, then read regs 0–5 -> bvalid one cycle after avalid; all reads 0; state=0.
- MASK=0, LIMIT=5, start; in_strobe every other cycle -> comp_clear 1 cycle; exactly 5 out_strobe; SAMPLE_COUNT=5; limit_hit=1; done 2 cycles after DRAIN entry; state back to 0.
- MASK=0x0001, VALUE=0x0001, s=0, start; in_strobe pulsing; raise s[0] after 10 cycles -> no out_strobe while ARMED; strobes pass from RUN entry onward.
- LIMIT=0, start, 100 strobes, write stop -> SAMPLE_COUNT=100; DRAIN drops strobes; done pulses; limit_hit=0.
- During RUN: abort, then separately pulse comp_overflow -> abort returns to IDLE with no done. comp_overflow sets CTRL bit8; bit8 persists in IDLE; the next start clears it.
- Write start|abort in IDLE, then start while in RUN -> state stays 0, then RUN unaffected; counters not zeroed by the ignored start.
